univ_shift_register: RTL

UNIV_SHIFT_REGISTER -- requirements
Module: univ_shift_register

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_step.sv | 53 +++++
 rtl/univ_shift_register.sv | 107 ++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register:
// operation modes and burst controller states.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHRL  = 3'b010;
  localparam logic [2:0] MODE_SHRA  = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_LOAD  = 3'b110;
  localparam logic [2:0] MODE_HOLD2 = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One step of the register: next data value and the bit
// shifted/rotated out, for a given mode.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_load,
  input  logic             i_sin,
  input  logic             i_so,
  output logic [WIDTH-1:0] o_d,
  output logic             o_so
);

  always_comb begin
    o_d  = i_d;
    o_so = i_so;
    unique case (i_mode)
      MODE_SHL: begin
        o_d  = {i_d[WIDTH-2:0], i_sin};
        o_so = i_d[WIDTH-1];
      end
      MODE_SHRL: begin
        o_d  = {i_sin, i_d[WIDTH-1:1]};
        o_so = i_d[0];
      end
      MODE_SHRA: begin
        o_d  = {i_d[WIDTH-1], i_d[WIDTH-1:1]};
        o_so = i_d[0];
      end
      MODE_ROL: begin
        o_d  = {i_d[WIDTH-2:0], i_d[WIDTH-1]};
        o_so = i_d[WIDTH-1];
      end
      MODE_ROR: begin
        o_d  = {i_d[0], i_d[WIDTH-1:1]};
        o_so = i_d[0];
      end
      MODE_LOAD: o_d = i_load;
      MODE_HOLD, MODE_HOLD2: begin
        o_d  = i_d;
        o_so = i_so;
      end
      default: begin
        o_d  = i_d;
        o_so = i_so;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_register.sv
// Universal shift register with single-step operation and
// counted bursts in a latched mode.
module univ_shift_register
  import shift_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic             serialIn,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] dataOut,
  output logic             serialOut,
  output logic             busy,
  output logic             done
);

  state_t           r_state, w_state_n;
  logic [2:0]       r_mode, w_mode_n;
  logic [CNT_W-1:0] r_rem, w_rem_n;
  logic [WIDTH-1:0] r_data, w_data_n;
  logic             r_so, w_so_n;
  logic             r_done, w_done_n;

  logic [2:0]       w_step_mode;
  logic [WIDTH-1:0] w_step_d;
  logic             w_step_so;
  logic [CNT_W-1:0] w_cnt_sat;

  assign w_step_mode = (r_state == ST_BURST) ? r_mode : mode;
  assign w_cnt_sat   = (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH)
                                               : count;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_mode (w_step_mode),
    .i_d    (r_data),
    .i_load (dataIn),
    .i_sin  (serialIn),
    .i_so   (r_so),
    .o_d    (w_step_d),
    .o_so   (w_step_so)
  );

  always_comb begin
    w_state_n = r_state;
    w_mode_n  = r_mode;
    w_rem_n   = r_rem;
    w_data_n  = r_data;
    w_so_n    = r_so;
    w_done_n  = 1'b0;
    if (enable) begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_mode_n = mode;
            w_rem_n  = w_cnt_sat;
            // a zero-length burst completes without ever going busy
            if (w_cnt_sat == '0) w_done_n = 1'b1;
            else                 w_state_n = ST_BURST;
          end else begin
            w_data_n = w_step_d;
            w_so_n   = w_step_so;
          end
        end
        ST_BURST: begin
          w_data_n = w_step_d;
          w_so_n   = w_step_so;
          w_rem_n  = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            w_state_n = ST_IDLE;
            w_done_n  = 1'b1;
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_HOLD;
      r_rem   <= '0;
      r_data  <= '0;
      r_so    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_mode  <= w_mode_n;
      r_rem   <= w_rem_n;
      r_data  <= w_data_n;
      r_so    <= w_so_n;
      r_done  <= w_done_n;
    end
  end

  assign dataOut   = r_data;
  assign serialOut = r_so;
  assign busy      = (r_state == ST_BURST);
  assign done      = r_done;

endmodule
